// File: rtl/gps_pkg.sv
// Shared types and widths for the GPS point interface.
//   COORD_W : width of one longitude or latitude word
//   D_W     : width of the distance result
//   A_W     : width of the intermediate term
//   state_e : transmit FSM states
//   coord_t : one buffered {lon, lat} pair
package gps_pkg;

    localparam int unsigned COORD_W = 24;
    localparam int unsigned D_W     = 40;
    localparam int unsigned A_W     = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT,
        ST_GAP
    } state_e;

    typedef struct packed {
        logic [COORD_W-1:0] lon;
        logic [COORD_W-1:0] lat;
    } coord_t;

endpackage

// File: rtl/gps_coord_fifo.sv
// Synchronous FIFO of coordinate pairs.
//   clk, reset_n   : clock, asynchronous active-low reset
//   push_i/data_i  : push strobe and entry to store
//   pop_i          : remove head entry (ignored when empty)
//   head_o         : current head entry
//   full_o/empty_o : registered occupancy flags
//   level_o        : registered occupancy count
//   drop_o         : push rejected this cycle (full with no pop)
module gps_coord_fifo
    import gps_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push_i,
    input  coord_t        data_i,
    input  logic          pop_i,
    output coord_t        head_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   level_o,
    output logic          drop_o
);

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    coord_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q, count_d;
    logic            full_q, empty_q;
    logic            push_ok, pop_ok;

    // A push into a full FIFO is still accepted when the head leaves in the same cycle.
    assign pop_ok  = pop_i && !empty_q;
    assign push_ok = push_i && (!full_q || pop_ok);
    assign drop_o  = push_i && !push_ok;

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == FULL_LVL);
            empty_q <= (count_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign level_o = count_q;

endmodule

// File: rtl/gps_point_tx.sv
// Transmit side of the GPS distance calculator's point interface.
//   clk, reset_n           : clock, asynchronous active-low reset
//   wr_en/wr_lon/wr_lat    : producer push into the point FIFO
//   full/empty/level       : FIFO status
//   seq_clr                : next point starts a new sequence (honoured in IDLE)
//   DEN/LON_IN/LAT_IN      : one-cycle point strobe and coordinates to calculator
//   Valid/D/a              : result strobe and values from calculator
//   res_valid/res_D/res_a  : captured result, pulse on capture
//   res_cnt                : wrapping count of captured results
//   err_timeout/ovf/stray  : sticky error flags
module gps_point_tx
    import gps_pkg::*;
#(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned TIMEOUT = 4096,
    parameter int unsigned GAP_CYC = 2,
    localparam int unsigned AW     = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               wr_en,
    input  logic [COORD_W-1:0] wr_lon,
    input  logic [COORD_W-1:0] wr_lat,
    output logic               full,
    output logic               empty,
    output logic [AW:0]        level,
    input  logic               seq_clr,
    output logic               DEN,
    output logic [COORD_W-1:0] LON_IN,
    output logic [COORD_W-1:0] LAT_IN,
    input  logic               Valid,
    input  logic [D_W-1:0]     D,
    input  logic [A_W-1:0]     a,
    output logic               res_valid,
    output logic [D_W-1:0]     res_D,
    output logic [A_W-1:0]     res_a,
    output logic [15:0]        res_cnt,
    output logic               err_timeout,
    output logic               err_ovf,
    output logic               err_stray
);

    localparam int unsigned TW       = $clog2(TIMEOUT + 1);
    localparam int unsigned GW       = $clog2(GAP_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

    state_e              state_q, state_d;
    logic                den_q, den_d;
    logic [COORD_W-1:0]  lon_q, lon_d, lat_q, lat_d;
    logic                rv_q, rv_d;
    logic [D_W-1:0]      rd_q, rd_d;
    logic [A_W-1:0]      ra_q, ra_d;
    logic [15:0]         rcnt_q, rcnt_d;
    logic                first_q, first_d;
    logic [TW-1:0]       tcnt_q, tcnt_d;
    logic [GW-1:0]       gcnt_q, gcnt_d;
    logic                etmo_q, etmo_d, eovf_q, eovf_d, estr_q, estr_d;

    coord_t              head;
    logic                pop, fifo_drop;

    gps_coord_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (wr_en),
        .data_i  ('{lon: wr_lon, lat: wr_lat}),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level),
        .drop_o  (fifo_drop)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (!seq_clr && !empty)            state_d = ST_SEND;
            ST_SEND: state_d = first_q ? ST_GAP : ST_WAIT;
            ST_WAIT: if (Valid || tcnt_q == TMO_LAST)   state_d = ST_GAP;
            ST_GAP:  if (gcnt_q == GAP_LAST)            state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        den_d   = 1'b0;
        lon_d   = lon_q;
        lat_d   = lat_q;
        pop     = 1'b0;
        rv_d    = 1'b0;
        rd_d    = rd_q;
        ra_d    = ra_q;
        rcnt_d  = rcnt_q;
        first_d = first_q;
        tcnt_d  = tcnt_q;
        gcnt_d  = gcnt_q;
        etmo_d  = etmo_q;
        eovf_d  = eovf_q | fifo_drop;
        estr_d  = estr_q;
        // Stray Valid is flagged first so a same-cycle seq_clr in IDLE still clears it.
        if (Valid && state_q != ST_WAIT) estr_d = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (seq_clr) begin
                    first_d = 1'b1;
                    etmo_d  = 1'b0;
                    estr_d  = 1'b0;
                end else if (!empty) begin
                    den_d = 1'b1;
                    lon_d = head.lon;
                    lat_d = head.lat;
                    pop   = 1'b1;
                end
            end
            ST_SEND: begin
                if (first_q) begin
                    first_d = 1'b0;
                    gcnt_d  = '0;
                end else begin
                    tcnt_d = '0;
                end
            end
            ST_WAIT: begin
                if (Valid) begin
                    rd_d   = D;
                    ra_d   = a;
                    rv_d   = 1'b1;
                    rcnt_d = rcnt_q + 16'd1;
                    gcnt_d = '0;
                end else if (tcnt_q == TMO_LAST) begin
                    etmo_d = 1'b1;
                    gcnt_d = '0;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (gcnt_q != GAP_LAST) gcnt_d = gcnt_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            den_q   <= 1'b0;
            lon_q   <= '0;
            lat_q   <= '0;
            rv_q    <= 1'b0;
            rd_q    <= '0;
            ra_q    <= '0;
            rcnt_q  <= '0;
            first_q <= 1'b1;
            tcnt_q  <= '0;
            gcnt_q  <= '0;
            etmo_q  <= 1'b0;
            eovf_q  <= 1'b0;
            estr_q  <= 1'b0;
        end else begin
            den_q   <= den_d;
            lon_q   <= lon_d;
            lat_q   <= lat_d;
            rv_q    <= rv_d;
            rd_q    <= rd_d;
            ra_q    <= ra_d;
            rcnt_q  <= rcnt_d;
            first_q <= first_d;
            tcnt_q  <= tcnt_d;
            gcnt_q  <= gcnt_d;
            etmo_q  <= etmo_d;
            eovf_q  <= eovf_d;
            estr_q  <= estr_d;
        end
    end

    assign DEN         = den_q;
    assign LON_IN      = lon_q;
    assign LAT_IN      = lat_q;
    assign res_valid   = rv_q;
    assign res_D       = rd_q;
    assign res_a       = ra_q;
    assign res_cnt     = rcnt_q;
    assign err_timeout = etmo_q;
    assign err_ovf     = eovf_q;
    assign err_stray   = estr_q;

endmodule
